// File: rtl/logic_op_sequencer.sv
// Micro-sequencer driving one shared 32-bit NOR/AND/INV/OR unit; builds NAND/XOR/XNOR in steps.
// Define LOGIC_SEQ_STATS_EN to add saturating STAT_OPS / STAT_BUSY counters.
module logic_op_sequencer #(
  parameter int                DW             = 32,
  parameter logic [DW-1:0]     ILLEGAL_RESULT = '0
`ifdef LOGIC_SEQ_STATS_EN
  , parameter int              STAT_W         = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_OP,
  input  logic [DW-1:0]     REQ_A,
  input  logic [DW-1:0]     REQ_B,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DW-1:0]     RSP_Y,
  output logic              RSP_ERR,
  output logic              BUSY
`ifdef LOGIC_SEQ_STATS_EN
  , output logic [STAT_W-1:0] STAT_OPS
  , output logic [STAT_W-1:0] STAT_BUSY
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_INV  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [1:0] P_NOR = 2'd0;
  localparam logic [1:0] P_AND = 2'd1;
  localparam logic [1:0] P_INV = 2'd2;
  localparam logic [1:0] P_OR  = 2'd3;

  localparam logic [1:0] D_T0 = 2'd0;
  localparam logic [1:0] D_T1 = 2'd1;
  localparam logic [1:0] D_Y  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    step_q, step_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] t0_q, t0_d;
  logic [DW-1:0] t1_q, t1_d;
  logic [DW-1:0] y_q, y_d;
  logic          err_q, err_d;

  logic [1:0]    prim_sel;
  logic [DW-1:0] prim_x;
  logic [DW-1:0] prim_z;
  logic [DW-1:0] prim_y;
  logic [1:0]    dst;
  logic          last;

  // Microcode: (op, step) selects the primitive, its operands and destination
  always_comb begin
    prim_sel = P_AND;
    prim_x   = a_q;
    prim_z   = b_q;
    dst      = D_Y;
    last     = 1'b1;
    case (op_q)
      OP_AND: prim_sel = P_AND;
      OP_OR:  prim_sel = P_OR;
      OP_NOR: prim_sel = P_NOR;
      OP_INV: prim_sel = P_INV;
      OP_NAND: begin
        if (step_q == 2'd0) begin
          prim_sel = P_AND;
          dst      = D_T0;
          last     = 1'b0;
        end else begin
          prim_sel = P_INV;
          prim_x   = t0_q;
        end
      end
      OP_XOR, OP_XNOR: begin
        case (step_q)
          2'd0: begin
            prim_sel = P_NOR;
            dst      = D_T0;
            last     = 1'b0;
          end
          2'd1: begin
            prim_sel = P_AND;
            dst      = D_T1;
            last     = 1'b0;
          end
          default: begin
            prim_sel = (op_q == OP_XOR) ? P_NOR : P_OR;
            prim_x   = t0_q;
            prim_z   = t1_q;
          end
        endcase
      end
      default: prim_sel = P_AND;
    endcase
  end

  // The single shared primitive unit
  always_comb begin
    prim_y = '0;
    case (prim_sel)
      P_NOR:   prim_y = ~(prim_x | prim_z);
      P_AND:   prim_y = prim_x & prim_z;
      P_INV:   prim_y = ~prim_x;
      P_OR:    prim_y = prim_x | prim_z;
      default: prim_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          op_d   = REQ_OP;
          a_d    = REQ_A;
          b_d    = REQ_B;
          step_d = 2'd0;
          if (REQ_OP == OP_ILL) begin
            y_d     = ILLEGAL_RESULT;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        case (dst)
          D_T0:    t0_d = prim_y;
          D_T1:    t1_d = prim_y;
          default: y_d  = prim_y;
        endcase
        if (last) state_d = S_RESP;
        else      step_d  = step_q + 2'd1;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_RESP);
  assign BUSY      = (state_q != S_IDLE);
  assign RSP_Y     = y_q;
  assign RSP_ERR   = err_q;

`ifdef LOGIC_SEQ_STATS_EN
  logic [STAT_W-1:0] stat_ops_q, stat_ops_d;
  logic [STAT_W-1:0] stat_busy_q, stat_busy_d;

  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_busy_d = stat_busy_q;
    if (RSP_VALID && RSP_READY && (stat_ops_q != '1))
      stat_ops_d = stat_ops_q + 1'b1;
    if (BUSY && (stat_busy_q != '1))
      stat_busy_d = stat_busy_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_busy_q <= stat_busy_d;
    end
  end

  assign STAT_OPS  = stat_ops_q;
  assign STAT_BUSY = stat_busy_q;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: latency, function, backpressure,
// illegal opcode and asynchronous reset mid-operation.
module tb_logic_op_sequencer;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [31:0] REQ_B;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_Y;
  logic        RSP_ERR;
  logic        BUSY;
`ifdef LOGIC_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_busy;
`endif

  int n_vec;
  int n_err;

  logic_op_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_Y     (RSP_Y),
    .RSP_ERR   (RSP_ERR),
    .BUSY      (BUSY)
`ifdef LOGIC_SEQ_STATS_EN
    , .STAT_OPS  (stat_ops)
    , .STAT_BUSY (stat_busy)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op with RSP_READY=1; cycle 1 is the cycle after the accept edge
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y, input logic exp_err,
                        input int exp_cyc);
    int cyc;
    @(negedge CLK);
    REQ_OP    = op;
    REQ_A     = a;
    REQ_B     = b;
    REQ_VALID = 1'b1;
    RSP_READY = 1'b1;
    check({tag, "_rdy_in"}, {31'd0, REQ_READY}, 32'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_A     = ~a;
    REQ_B     = ~b;
    REQ_OP    = 3'b000;
    cyc = 1;
    @(negedge CLK);
    check({tag, "_rdy_busy"}, {31'd0, REQ_READY}, 32'd0);
    while (!RSP_VALID && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_cyc);
    check({tag, "_y"}, RSP_Y, exp_y);
    check({tag, "_err"}, {31'd0, RSP_ERR}, {31'd0, exp_err});
    @(negedge CLK);
    check({tag, "_rdy_out"}, {31'd0, REQ_READY}, 32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_OP    = 3'b000;
    REQ_A     = '0;
    REQ_B     = '0;
    RSP_READY = 1'b0;
    #12;
    check("rst_rdy", {31'd0, REQ_READY}, 32'd1);
    check("rst_vld", {31'd0, RSP_VALID}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_y", RSP_Y, 32'd0);
    check("rst_err", {31'd0, RSP_ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_op("and", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2);
    run_op("xor", 3'b101, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 1'b0, 4);
    run_op("xnor", 3'b110, 32'h12345678, 32'hFFFF0000, 32'h1234A987, 1'b0, 4);
    run_op("nand", 3'b100, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 3);
    run_op("inv", 3'b011, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 2);
    run_op("nor2", 3'b010, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 2);

    // Backpressure with REQ_* wiggling while the response is stalled
    @(negedge CLK);
    REQ_OP    = 3'b001;
    REQ_A     = 32'h0F0F0000;
    REQ_B     = 32'h000000F0;
    REQ_VALID = 1'b1;
    RSP_READY = 1'b0;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_vld", {31'd0, RSP_VALID}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      REQ_A     = REQ_A ^ 32'hFFFF_FFFF;
      REQ_VALID = ~REQ_VALID;
      @(negedge CLK);
      check("bp_y", RSP_Y, 32'h0F0F00F0);
      check("bp_hold", {29'd0, RSP_VALID, REQ_READY, BUSY}, 32'b101);
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("bp_done", {29'd0, RSP_VALID, REQ_READY, BUSY}, 32'b010);

    run_op("ill", 3'b111, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 1'b1, 1);
    run_op("nor", 3'b010, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2);

    // Asynchronous reset during XOR step 2 (cycle 3)
    @(negedge CLK);
    REQ_OP    = 3'b101;
    REQ_A     = 32'h12345678;
    REQ_B     = 32'hFFFF0000;
    REQ_VALID = 1'b1;
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("arst_out", {29'd0, REQ_READY, RSP_VALID, BUSY}, 32'b100);
    check("arst_y", RSP_Y, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("arst_norsp", {31'd0, RSP_VALID}, 32'd0);
    end
    run_op("and_rst", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2);
`ifdef LOGIC_SEQ_STATS_EN
    check("stat_ops", {16'd0, stat_ops}, 32'd1);
    check("stat_busy", {16'd0, stat_busy}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
